ham_dec: RTL

Dual-port pipelined SECDED Hamming decoder, the receive-side counterpart of `ham_enc`. It accepts the (ENCODED_WORD+1)-bit extended-Hamming codewords for port-a and port-b. For each codeword it computes the syndrome and overall parity, corrects any single-bit error, flags double-bit errors and extracts the data word. Error events are accumulated in shared saturating counters, and a sticky uncorrectable flag is kept for status readback.

---
 rtl/ham_dec.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ham_dec.sv
// ham_dec: dual-port, two-stage pipelined SECDED (extended Hamming) decoder.
// Each port corrects single-bit errors and flags double or invalid-position
// errors. Both ports feed shared saturating SEC/DED counters and a sticky DED flag.
module ham_dec #(
    parameter int DATA_WIDTH   = 32,
    parameter int ENCODED_WORD = 38,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_valid_a,
    input  logic                                   i_valid_b,
    input  logic [ENCODED_WORD+1:1]                i_hamming_a,
    input  logic [ENCODED_WORD+1:1]                i_hamming_b,
    input  logic                                   i_clr_cnt,
    output logic                                   o_valid_a,
    output logic                                   o_valid_b,
    output logic [DATA_WIDTH-1:0]                  o_data_a,
    output logic [DATA_WIDTH-1:0]                  o_data_b,
    output logic [$clog2(ENCODED_WORD+1)-1:0]      o_syndrome_a,
    output logic [$clog2(ENCODED_WORD+1)-1:0]      o_syndrome_b,
    output logic                                   o_sec_a,
    output logic                                   o_sec_b,
    output logic                                   o_ded_a,
    output logic                                   o_ded_b,
    output logic [CNT_WIDTH-1:0]                   o_sec_cnt,
    output logic [CNT_WIDTH-1:0]                   o_ded_cnt,
    output logic                                   o_ded_sticky
);

    localparam int SW = $clog2(ENCODED_WORD + 1);
    // Highest syndrome value that names a real bit position.
    localparam logic [SW-1:0] MAX_POS = SW'(ENCODED_WORD);

    // Positions checked by syndrome bit b: every k in 1..ENCODED_WORD with bit b set.
    function automatic logic [ENCODED_WORD+1:1] cover_mask(input int b);
        logic [ENCODED_WORD+1:1] m;
        m = '0;
        for (int k = 1; k <= ENCODED_WORD; k++) begin
            m[k] = ((k >> b) & 1) != 0;
        end
        return m;
    endfunction

    // Codeword position of data bit j: the j-th non-power-of-2 position.
    function automatic int data_pos(input int j);
        int cnt;
        cnt = 0;
        for (int k = 1; k <= ENCODED_WORD; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (cnt == j) return k;
                cnt++;
            end
        end
        return 1;
    endfunction

    // Counter add of 0..2 events that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH + 1)'(inc);
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // Number of ports reporting an event this cycle.
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Index 0 is port a, index 1 is port b.
    logic [1:0][ENCODED_WORD+1:1] cw_in;
    logic [1:0][DATA_WIDTH-1:0]   dat_in;
    logic [1:0][SW-1:0]           syn_in;
    logic [1:0]                   par_in;

    logic [1:0]                   vld_p1;
    logic [1:0][DATA_WIDTH-1:0]   dat_p1;
    logic [1:0][SW-1:0]           syn_p1;
    logic [1:0]                   par_p1;

    logic [1:0]                   sec_c;
    logic [1:0]                   ded_c;
    logic [1:0][DATA_WIDTH-1:0]   data_c;

    logic [1:0]                   vld_p2;
    logic [1:0]                   sec_p2;
    logic [1:0]                   ded_p2;
    logic [1:0][DATA_WIDTH-1:0]   data_p2;
    logic [1:0][SW-1:0]           syn_p2;

    logic [CNT_WIDTH-1:0]         sec_cnt;
    logic [CNT_WIDTH-1:0]         ded_cnt;
    logic                         ded_sticky;

    assign cw_in[0] = i_hamming_a;
    assign cw_in[1] = i_hamming_b;

    for (genvar p = 0; p < 2; p++) begin : g_port
        wire nz       = |syn_p1[p];
        wire in_range = syn_p1[p] <= MAX_POS;

        // ---- stage 0 -> 1: syndrome, overall parity, raw data gather ----
        for (genvar b = 0; b < SW; b++) begin : g_syn
            localparam logic [ENCODED_WORD+1:1] COVER = cover_mask(b);
            assign syn_in[p][b] = ^(cw_in[p] & COVER);
        end
        assign par_in[p] = ^cw_in[p];

        // ---- stage 1 -> 2: classify and correct ----
        // S=0 with odd parity is an error in the overall parity bit only.
        assign sec_c[p] = par_in_unused_guard(par_p1[p]) & (~nz | in_range);
        assign ded_c[p] = nz & (~par_p1[p] | ~in_range);

        for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_dat
            localparam int            POS   = data_pos(j);
            localparam logic [SW-1:0] POS_S = SW'(POS);
            // Only data positions are carried forward; a corrected parity-bit
            // error needs no data change, so the flip is applied here.
            assign dat_in[p][j] = cw_in[p][POS];
            assign data_c[p][j] = dat_p1[p][j] ^ (sec_c[p] & (syn_p1[p] == POS_S));
        end
    end

    // Identity helper keeping the SEC term readable next to the DED term.
    function automatic logic par_in_unused_guard(input logic par);
        return par;
    endfunction

    // Stage-1 valid: cleared on reset so in-flight words are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) vld_p1 <= '0;
        else          vld_p1 <= {i_valid_b, i_valid_a};
    end

    // Stage-1 payload: loaded every cycle, stale contents are masked by vld_p1.
    always_ff @(posedge i_clk) begin
        dat_p1 <= dat_in;
        syn_p1 <= syn_in;
        par_p1 <= par_in;
    end

    // Stage-2 result registers; flags are gated by valid so idle cycles read 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p2  <= '0;
            sec_p2  <= '0;
            ded_p2  <= '0;
            data_p2 <= '0;
            syn_p2  <= '0;
        end else begin
            vld_p2  <= vld_p1;
            sec_p2  <= vld_p1 & sec_c;
            ded_p2  <= vld_p1 & ded_c;
            data_p2 <= data_c;
            syn_p2  <= syn_p1;
        end
    end

    // Shared event counters and sticky DED; a clear beats a coincident event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr_cnt) begin
            sec_cnt    <= '0;
            ded_cnt    <= '0;
            ded_sticky <= 1'b0;
        end else begin
            sec_cnt    <= sat_add(sec_cnt, pop2(sec_p2));
            ded_cnt    <= sat_add(ded_cnt, pop2(ded_p2));
            ded_sticky <= ded_sticky | (|ded_p2);
        end
    end

    assign o_valid_a    = vld_p2[0];
    assign o_valid_b    = vld_p2[1];
    assign o_data_a     = data_p2[0];
    assign o_data_b     = data_p2[1];
    assign o_syndrome_a = syn_p2[0];
    assign o_syndrome_b = syn_p2[1];
    assign o_sec_a      = sec_p2[0];
    assign o_sec_b      = sec_p2[1];
    assign o_ded_a      = ded_p2[0];
    assign o_ded_b      = ded_p2[1];
    assign o_sec_cnt    = sec_cnt;
    assign o_ded_cnt    = ded_cnt;
    assign o_ded_sticky = ded_sticky;

endmodule
